prefetch_unit: RTL
==================

PREFETCH_UNIT -- requirements
Module: prefetch_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, address/PC width.
REQ-002 SHALL have parameter DEPTH, default 4, instruction queue entries (power of two, >=2).
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port imem_req_valid  output  1  fetch request pending.
REQ-007 SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-008 SHALL have port imem_req_addr  output  XLEN  fetch address, word aligned.
REQ-009 SHALL have port imem_resp_valid  input  1  instruction word returned, in order.
REQ-010 SHALL have port imem_resp_data  input  32  returned instruction.
REQ-011 SHALL have port redirect_valid  input  1  branch/jump/trap redirect, one-cycle pulse.
REQ-012 SHALL have port redirect_pc  input  XLEN  new fetch target.
REQ-013 SHALL have port inst_valid  output  1  head instruction available.
REQ-014 SHALL have port inst_ready  input  1  decode consumes head.
REQ-015 SHALL have port inst_data  output  32  head instruction.
REQ-016 SHALL have port inst_pc  output  XLEN  PC of head instruction.

Function
REQ-017 SHALL hold fetch PC fpc; a request handshake (valid&ready) SHALL advance fpc by 4, wrapping modulo 2^XLEN.
REQ-018 SHALL assert imem_req_valid iff allocated entries (filled + in flight) < DEPTH and redirect_valid is low; imem_req_addr SHALL equal fpc.
REQ-019 SHALL allocate the tail slot and record its PC at request handshake; the matching response SHALL fill that slot; responses SHALL be accepted at any latency >=1 cycle.
REQ-020 SHALL drive inst_valid combinationally from the head slot's filled bit; inst_data/inst_pc from head slot; pop on inst_valid&inst_ready.
REQ-021 SHALL sustain one request, one response and one pop in the same cycle (throughput 1 instr/cycle at steady state).
REQ-022 On redirect_valid: at next edge queue SHALL empty, fpc SHALL load {redirect_pc[XLEN-1:2],2'b00}, drop counter SHALL load in-flight count (+1 if a response arrives but is not yet counted this cycle is excluded: drop counts requests not yet answered after this edge).
REQ-023 While drop counter > 0, each imem_resp_valid SHALL decrement it and discard data; no slot written.
REQ-024 A pop coinciding with redirect_valid SHALL complete as a normal pop; a request SHALL NOT be issued in the redirect cycle.
REQ-025 Back-to-back redirects SHALL accumulate drops correctly; last redirect_pc wins.
REQ-026 imem_resp_valid with zero in-flight and zero drop SHALL be ignored.
REQ-027 imem_req_valid/addr SHALL remain stable until accepted, except a redirect may withdraw it.

Reset
REQ-028 While rst=0: fpc=RESET_PC, queue empty, drop=0, in-flight=0, imem_req_valid=0, inst_valid=0, inst_data=0, inst_pc=0.
REQ-029 Reset mid-transaction SHALL abandon in-flight responses; first request SHALL follow the first edge after rst rises.

Structure
REQ-030 SHALL place XLEN default, instruction width 32, NOP encoding 32'h0000_0013 and RESET_PC default in shared package rv32i_pkg.
REQ-031 SHALL implement slot storage in one sub-module fetch_queue (head/tail pointers log2(DEPTH)+1 bits, per-slot pc/data/filled).
REQ-032 Drop and in-flight counters SHALL be log2(DEPTH)+1 bits, never overflow.

Verification
REQ-033 Reset release, imem_req_ready=1, 1-cycle latency, inst_ready=1 -> inst_pc 0x0,0x4,0x8... on consecutive cycles, one per cycle.
REQ-034 inst_ready=0, DEPTH=4 -> exactly 4 requests (0x0..0xC) issued, imem_req_valid then low until a pop.
REQ-035 3 requests in flight, redirect_pc=0x103 -> next 3 responses discarded, next request addr 0x100, first inst_pc 0x100.
REQ-036 Redirect at 0x40 then 0x80 next cycle with 2 in flight -> all stale dropped, first inst_pc 0x80.
REQ-037 imem_req_ready toggling, latency 3 -> addr held stable while stalled, order and data preserved.
REQ-038 rst low with 2 in flight, released -> first request addr RESET_PC, late responses ignored.

Source files
------------

// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_pkg
// Description : Shared RV32I front-end constants and types used by the
//               prefetch unit and its instruction queue.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_pkg;

   localparam int unsigned c_xlen     = 32;
   localparam int unsigned c_ilen     = 32;
   localparam logic [31:0] c_nop      = 32'h0000_0013;
   localparam logic [31:0] c_reset_pc = 32'h0000_0000;

   // What happens to an incoming memory response in a given cycle
   typedef enum logic [1:0] {
      RESP_IGNORE = 2'd0,   // no response, or nothing outstanding
      RESP_DROP   = 2'd1,   // answers a request made before a redirect
      RESP_FILL   = 2'd2    // answers a live request, written into the queue
   } resp_disp_e;

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : In-order instruction queue. A slot is allocated (with its PC)
//               when the fetch request is accepted and filled later when the
//               matching response returns. The head is presented to decode
//               as soon as its slot is filled.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
   import rv32i_pkg::*;
#(
   parameter int unsigned XLEN  = c_xlen,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     alloc,
   input  logic [XLEN-1:0]          alloc_pc,
   input  logic                     fill,
   input  logic [c_ilen-1:0]        fill_data,
   input  logic                     pop,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     head_valid,
   output logic [c_ilen-1:0]        head_data,
   output logic [XLEN-1:0]          head_pc
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [PW-1:0]     r_head;
   logic [PW-1:0]     r_tail;
   logic [PW-1:0]     r_fill;
   logic [XLEN-1:0]   r_pc     [DEPTH];
   logic [c_ilen-1:0] r_data   [DEPTH];
   logic [DEPTH-1:0]  r_filled;

   logic [AW-1:0]     w_head_idx;
   logic [AW-1:0]     w_tail_idx;
   logic [AW-1:0]     w_fill_idx;

   assign w_head_idx = r_head[AW-1:0];
   assign w_tail_idx = r_tail[AW-1:0];
   assign w_fill_idx = r_fill[AW-1:0];

   // Extra pointer bit distinguishes full from empty
   assign count      = r_tail - r_head;
   assign head_valid = (count != '0) && r_filled[w_head_idx];
   assign head_data  = r_data[w_head_idx];
   assign head_pc    = r_pc[w_head_idx];

   // Pointer bookkeeping; a flush discards every allocated slot at once
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_head <= '0;
         r_tail <= '0;
         r_fill <= '0;
      end else if (flush) begin
         r_head <= '0;
         r_tail <= '0;
         r_fill <= '0;
      end else begin
         if (pop)   r_head <= r_head + 1'b1;
         if (alloc) r_tail <= r_tail + 1'b1;
         if (fill)  r_fill <= r_fill + 1'b1;
      end
   end

   // Slot storage: record PC on allocation, data and filled bit on response
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_pc[i]     <= '0;
            r_data[i]   <= '0;
            r_filled[i] <= 1'b0;
         end
      end else begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            if (flush) begin
               r_filled[i] <= 1'b0;
            end else begin
               if (alloc && (w_tail_idx == AW'(i))) begin
                  r_pc[i]     <= alloc_pc;
                  r_filled[i] <= 1'b0;
               end
               if (fill && (w_fill_idx == AW'(i))) begin
                  r_data[i]   <= fill_data;
                  r_filled[i] <= 1'b1;
               end
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : prefetch_unit
// Description : Instruction prefetcher. Issues sequential word fetches into
//               a small queue, delivers them in order to decode, and handles
//               redirects by flushing the queue and discarding responses to
//               requests that were still outstanding.
// Revision    : 1.0 - initial release
// ============================================================================
module prefetch_unit
   import rv32i_pkg::*;
#(
   parameter int unsigned     XLEN     = c_xlen,
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(c_reset_pc)
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req_valid,
   input  logic               imem_req_ready,
   output logic [XLEN-1:0]    imem_req_addr,
   input  logic               imem_resp_valid,
   input  logic [c_ilen-1:0]  imem_resp_data,
   input  logic               redirect_valid,
   input  logic [XLEN-1:0]    redirect_pc,
   output logic               inst_valid,
   input  logic               inst_ready,
   output logic [c_ilen-1:0]  inst_data,
   output logic [XLEN-1:0]    inst_pc
);

   localparam int unsigned     CW          = $clog2(DEPTH) + 1;
   localparam logic [CW:0]     c_depth_ext = (CW+1)'(DEPTH);

   logic [XLEN-1:0] r_fpc;
   logic            r_run;
   logic [CW-1:0]   r_inflight;
   logic [CW-1:0]   r_drop;

   resp_disp_e      w_resp_disp;
   logic            w_req_fire;
   logic            w_drop_dec;
   logic            w_fill;
   logic            w_pop;
   logic [CW-1:0]   w_count;
   logic [CW:0]     w_outstanding;
   logic            w_room;
   logic            w_unused;

   // Low PC bits of a redirect target are discarded by word alignment
   assign w_unused = ^redirect_pc[1:0];

   // Stale responses still occupy memory-side slots, so they count against
   // capacity; this also keeps drop + in-flight bounded by DEPTH.
   assign w_outstanding  = {1'b0, w_count} + {1'b0, r_drop};
   assign w_room         = (w_outstanding < c_depth_ext);
   assign imem_req_valid = r_run && w_room && !redirect_valid;
   assign imem_req_addr  = r_fpc;
   assign w_req_fire     = imem_req_valid && imem_req_ready;
   assign w_pop          = inst_valid && inst_ready;

   // Classify the incoming response: stale ones are consumed first
   always_comb begin
      w_resp_disp = RESP_IGNORE;
      if (imem_resp_valid) begin
         if (r_drop != '0)          w_resp_disp = RESP_DROP;
         else if (r_inflight != '0) w_resp_disp = RESP_FILL;
      end
   end

   assign w_drop_dec = (w_resp_disp == RESP_DROP);
   assign w_fill     = (w_resp_disp == RESP_FILL);

   // Fetch PC and the one-cycle start-up delay after reset release
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_fpc <= RESET_PC;
         r_run <= 1'b0;
      end else begin
         r_run <= 1'b1;
         if (redirect_valid)  r_fpc <= {redirect_pc[XLEN-1:2], 2'b00};
         else if (w_req_fire) r_fpc <= r_fpc + XLEN'(4);
      end
   end

   // Outstanding-request counters; a redirect turns every unanswered live
   // request into one that must be dropped when it returns.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_inflight <= '0;
         r_drop     <= '0;
      end else if (redirect_valid) begin
         r_inflight <= '0;
         r_drop     <= r_drop - CW'(w_drop_dec) + r_inflight - CW'(w_fill);
      end else begin
         r_inflight <= r_inflight + CW'(w_req_fire) - CW'(w_fill);
         r_drop     <= r_drop - CW'(w_drop_dec);
      end
   end

   fetch_queue #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH)
   ) u_queue (
      .clk        (clk),
      .rst        (rst),
      .flush      (redirect_valid),
      .alloc      (w_req_fire),
      .alloc_pc   (r_fpc),
      .fill       (w_fill),
      .fill_data  (imem_resp_data),
      .pop        (w_pop),
      .count      (w_count),
      .head_valid (inst_valid),
      .head_data  (inst_data),
      .head_pc    (inst_pc)
   );

endmodule
`default_nettype wire
